// File: rtl/alarm_pkg.sv
// Shared defaults and slot-state type for the alarm scheduler.
package alarm_pkg;

  localparam int unsigned N_SLOTS = 4;
  localparam int unsigned TW      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant of the lowest set request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (32'(i_ptr) + k) % N;
      if (!o_valid && i_req[j[PW-1:0]]) begin
        o_valid             = 1'b1;
        o_idx               = j[PW-1:0];
        o_grant[j[PW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: round-robin arming, wrap-safe expiry, one fire pulse per cycle.
module alarm_scheduler #(
  parameter int unsigned N_SLOTS = alarm_pkg::N_SLOTS,
  parameter int unsigned TW      = alarm_pkg::TW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TW-1:0]         cur_time,
  input  logic [N_SLOTS-1:0]    req_valid,
  input  logic [N_SLOTS*TW-1:0] req_delay,
  input  logic [N_SLOTS-1:0]    req_periodic,
  input  logic [N_SLOTS-1:0]    cancel,
  output logic [N_SLOTS-1:0]    req_ready,
  output logic [N_SLOTS-1:0]    fire,
  output logic [N_SLOTS-1:0]    armed
);

  import alarm_pkg::*;

  localparam int unsigned PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  slot_state_e          r_state    [N_SLOTS];
  logic [TW-1:0]        r_deadline [N_SLOTS];
  logic [TW-1:0]        r_period   [N_SLOTS];
  logic [N_SLOTS-1:0]   r_periodic;
  logic [PW-1:0]        r_arm_ptr;
  logic [PW-1:0]        r_fire_ptr;
  logic [N_SLOTS-1:0]   r_fire;

  logic [N_SLOTS-1:0]   w_arm_grant;
  logic [PW-1:0]        w_arm_idx;
  logic                 w_arm_any;
  logic [N_SLOTS-1:0]   w_fire_req;
  logic [N_SLOTS-1:0]   w_fire_grant;
  logic [PW-1:0]        w_fire_idx;
  logic                 w_fire_any;
  logic [N_SLOTS-1:0]   w_hit;
  logic [N_SLOTS-1:0]   w_expired;
  logic [TW-1:0]        w_age   [N_SLOTS];
  logic [TW-1:0]        w_delay [N_SLOTS];
  logic [N_SLOTS-1:0]   w_unused_delay_msb;

  rr_arbiter #(.N(N_SLOTS), .PW(PW)) u_arm_arb (
    .i_req   (req_valid),
    .i_ptr   (r_arm_ptr),
    .o_grant (w_arm_grant),
    .o_idx   (w_arm_idx),
    .o_valid (w_arm_any)
  );

  // Cancelled or freshly armed slots must not be chosen for firing this cycle.
  assign w_fire_req = w_expired & ~cancel & ~w_arm_grant;

  rr_arbiter #(.N(N_SLOTS), .PW(PW)) u_fire_arb (
    .i_req   (w_fire_req),
    .i_ptr   (r_fire_ptr),
    .o_grant (w_fire_grant),
    .o_idx   (w_fire_idx),
    .o_valid (w_fire_any)
  );

  // Expiry is the sign of (now - deadline), so deadlines straddling the wrap still work.
  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      w_age[i]              = cur_time - r_deadline[i];
      w_hit[i]              = ~w_age[i][TW-1];
      w_expired[i]          = (r_state[i] == EXPIRED);
      armed[i]              = (r_state[i] != IDLE);
      w_delay[i]            = {1'b0, req_delay[i*TW +: TW-1]};
      w_unused_delay_msb[i] = req_delay[i*TW + TW - 1];
    end
  end

  assign req_ready = w_arm_grant;
  assign fire      = r_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_ptr  <= '0;
      r_fire_ptr <= '0;
      r_fire     <= '0;
      r_periodic <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        r_state[i]    <= IDLE;
        r_deadline[i] <= '0;
        r_period[i]   <= '0;
      end
    end else begin
      if (w_arm_any)
        r_arm_ptr <= (w_arm_idx == PW'(N_SLOTS - 1)) ? '0 : w_arm_idx + 1'b1;
      if (w_fire_any)
        r_fire_ptr <= (w_fire_idx == PW'(N_SLOTS - 1)) ? '0 : w_fire_idx + 1'b1;
      r_fire <= w_fire_grant;

      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        if (cancel[i]) begin
          r_state[i] <= IDLE;
        end else if (w_arm_grant[i]) begin
          r_state[i]    <= ARMED;
          r_deadline[i] <= cur_time + w_delay[i];
          r_period[i]   <= w_delay[i];
          r_periodic[i] <= req_periodic[i];
        end else if (w_fire_grant[i]) begin
          if (r_periodic[i]) begin
            r_state[i]    <= ARMED;
            r_deadline[i] <= r_deadline[i] + r_period[i];
          end else begin
            r_state[i] <= IDLE;
          end
        end else if (r_state[i] == ARMED && w_hit[i]) begin
          r_state[i] <= EXPIRED;
        end
      end
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with a per-cycle reference model and pinned literal checks.
module tb_alarm_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cur_time = '0;
  logic [3:0]  req_valid;
  logic [63:0] req_delay;
  logic [3:0]  req_periodic;
  logic [3:0]  cancel;
  logic [3:0]  req_ready;
  logic [3:0]  fire;
  logic [3:0]  armed;
  logic        jump_req;
  logic [15:0] jump_val;

  int checks   = 0;
  int failures = 0;

  alarm_scheduler #(.N_SLOTS(4), .TW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cur_time     (cur_time),
    .req_valid    (req_valid),
    .req_delay    (req_delay),
    .req_periodic (req_periodic),
    .cancel       (cancel),
    .req_ready    (req_ready),
    .fire         (fire),
    .armed        (armed)
  );

  always #5 clk = ~clk;

  // Timekeeper: +1 per clock, with an optional jump to reach the wrap quickly.
  always @(posedge clk) cur_time <= jump_req ? jump_val : cur_time + 16'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t cur_time=%h)", nm, act, exp, $time, cur_time);
    end
  endtask

  task automatic wait_cur(input logic [15:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (cur_time != v && n < 300);
    if (cur_time != v) begin
      checks++;
      failures++;
      $display("FAIL wait_cur: timed out at %h waiting for %h", cur_time, v);
    end
  endtask

  // Reference model: slots as plain integers, expiry via signed time difference.
  int          m_state [4];
  logic [15:0] m_dl    [4];
  logic [15:0] m_per   [4];
  bit          m_pd    [4];
  int          m_aptr;
  int          m_fptr;
  logic [3:0]  m_fire;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int         ga;
    int         gf;
    logic [3:0] elig;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_state[i] = 0; m_dl[i] = '0; m_per[i] = '0; m_pd[i] = 1'b0;
      end
      m_aptr = 0; m_fptr = 0; m_fire = '0;
    end else begin
      ga = pick(req_valid, m_aptr);
      for (int i = 0; i < 4; i++)
        elig[i] = (m_state[i] == 2) && !cancel[i] && (ga != i);
      gf = pick(elig, m_fptr);
      if (ga >= 0) m_aptr = (ga + 1) % 4;
      if (gf >= 0) m_fptr = (gf + 1) % 4;
      m_fire = (gf >= 0) ? (4'b0001 << gf) : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (cancel[i]) begin
          m_state[i] = 0;
        end else if (ga == i) begin
          m_per[i]   = req_delay[i*16 +: 16] & 16'h7FFF;
          m_dl[i]    = cur_time + m_per[i];
          m_pd[i]    = req_periodic[i];
          m_state[i] = 1;
        end else if (gf == i) begin
          if (m_pd[i]) begin
            m_dl[i]    = m_dl[i] + m_per[i];
            m_state[i] = 1;
          end else begin
            m_state[i] = 0;
          end
        end else if (m_state[i] == 1 && $signed(cur_time - m_dl[i]) >= 0) begin
          m_state[i] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_armed;
    logic [3:0] exp_ready;
    int         g;
    for (int i = 0; i < 4; i++) exp_armed[i] = (m_state[i] != 0);
    g = pick(req_valid, m_aptr);
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("model_fire", 32'(fire), 32'(m_fire));
    chk("model_armed", 32'(armed), 32'(exp_armed));
    chk("model_ready", 32'(req_ready), 32'(exp_ready));
  end

  initial begin
    int cnt;
    req_valid = '0; req_delay = '0; req_periodic = '0; cancel = '0;
    jump_req = 1'b0; jump_val = '0;

    wait_cur(16'd2); #4;
    chk("reset_armed", 32'(armed), 32'h0);
    chk("reset_fire", 32'(fire), 32'h0);
    wait_cur(16'd3); rst_n = 1'b1;

    // One-shot slot 0; delay MSB must be ignored.
    wait_cur(16'd10); req_valid = 4'b0001; req_delay[15:0] = 16'h8005;
    #4 chk("oneshot_ready", 32'(req_ready), 32'h1);
    wait_cur(16'd11); req_valid = '0;
    wait_cur(16'd16); #4 chk("oneshot_fire_early", 32'(fire), 32'h0);
    chk("oneshot_armed_before", 32'(armed), 32'h1);
    wait_cur(16'd17); #4 chk("oneshot_fire", 32'(fire), 32'h1);
    chk("oneshot_armed_after", 32'(armed), 32'h0);
    wait_cur(16'd18); #4 chk("oneshot_fire_single", 32'(fire), 32'h0);

    // Reset pulse, then all four request on the release cycle.
    wait_cur(16'd35); rst_n = 1'b0;
    wait_cur(16'd40); rst_n = 1'b1; req_valid = 4'b1111; req_delay = {4{16'h0003}};
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        wait_cur(16'(40 + j));
        req_valid = 4'b1111 << j;
      end
      #4 chk("allfour_ready", 32'(req_ready), 32'(4'b0001 << j));
    end
    wait_cur(16'd44); req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      wait_cur(16'(45 + j));
      #4 chk("allfour_fire", 32'(fire), 32'(4'b0001 << j));
    end

    // Slots 1 and 2 expire on the same edge.
    wait_cur(16'd60); req_valid = 4'b0110; req_delay = '0;
    req_delay[31:16] = 16'd6; req_delay[47:32] = 16'd5;
    #4 chk("same_edge_ready1", 32'(req_ready), 32'h2);
    wait_cur(16'd61); req_valid = 4'b0100;
    #4 chk("same_edge_ready2", 32'(req_ready), 32'h4);
    wait_cur(16'd62); req_valid = '0;
    wait_cur(16'd67); #4 chk("same_edge_pre", 32'(fire), 32'h0);
    wait_cur(16'd68); #4 chk("same_edge_fire1", 32'(fire), 32'h2);
    wait_cur(16'd69); #4 chk("same_edge_fire2", 32'(fire), 32'h4);
    wait_cur(16'd70); #4 chk("same_edge_post", 32'(fire), 32'h0);

    // Periodic slot 3 across the time wrap.
    wait_cur(16'd80); jump_req = 1'b1; jump_val = 16'hFFF0;
    wait_cur(16'hFFF0); jump_req = 1'b0;
    wait_cur(16'hFFFC); req_valid = 4'b1000; req_delay = '0; req_delay[63:48] = 16'd4;
    req_periodic = 4'b1000;
    #4 chk("periodic_ready", 32'(req_ready), 32'h8);
    wait_cur(16'hFFFD); req_valid = '0; req_periodic = '0;
    wait_cur(16'd1);  #4 chk("periodic_quiet1", 32'(fire), 32'h0);
    wait_cur(16'd2);  #4 chk("periodic_fire0", 32'(fire), 32'h8);
    wait_cur(16'd3);  #4 chk("periodic_quiet3", 32'(fire), 32'h0);
    wait_cur(16'd6);  #4 chk("periodic_fire4", 32'(fire), 32'h8);
    wait_cur(16'd10); #4 chk("periodic_fire8", 32'(fire), 32'h8);
    wait_cur(16'd11); cancel = 4'b1000;
    #4 chk("periodic_armed_pre_cancel", 32'(armed), 32'h8);
    wait_cur(16'd12); cancel = '0;
    #4 chk("periodic_cancelled", 32'(armed), 32'h0);
    wait_cur(16'd14); #4 chk("periodic_no_more", 32'(fire), 32'h0);

    // Cancel plus arm on an expired slot.
    wait_cur(16'd30); req_valid = 4'b0010; req_delay = '0; req_delay[31:16] = 16'd2;
    #4 chk("cancel_arm_ready", 32'(req_ready), 32'h2);
    wait_cur(16'd31); req_valid = '0;
    wait_cur(16'd33); req_valid = 4'b0010; cancel = 4'b0010;
    #4 chk("cancel_ready", 32'(req_ready), 32'h2);
    chk("cancel_armed_pre", 32'(armed), 32'h2);
    wait_cur(16'd34); req_valid = '0; cancel = '0;
    #4 chk("cancel_no_fire", 32'(fire), 32'h0);
    chk("cancel_idle", 32'(armed), 32'h0);

    // Zero delay on slot 2.
    wait_cur(16'd36); req_valid = 4'b0100; req_delay = '0;
    #4 chk("zero_ready", 32'(req_ready), 32'h4);
    wait_cur(16'd37); req_valid = '0;
    wait_cur(16'd38); #4 chk("zero_pre", 32'(fire), 32'h0);
    wait_cur(16'd39); #4 chk("zero_fire", 32'(fire), 32'h4);

    // Reset with slots 0-2 armed discards them.
    wait_cur(16'd40); req_valid = 4'b0111; req_delay = {4{16'd100}};
    #4 chk("rst_arm_ready0", 32'(req_ready), 32'h1);
    wait_cur(16'd41); req_valid = 4'b0110;
    #4 chk("rst_arm_ready1", 32'(req_ready), 32'h2);
    wait_cur(16'd42); req_valid = 4'b0100;
    #4 chk("rst_arm_ready2", 32'(req_ready), 32'h4);
    wait_cur(16'd43); req_valid = '0;
    wait_cur(16'd49); #4 chk("rst_armed_before", 32'(armed), 32'h7);
    wait_cur(16'd50); rst_n = 1'b0;
    #4 chk("rst_armed_during", 32'(armed), 32'h0);
    chk("rst_fire_during", 32'(fire), 32'h0);
    wait_cur(16'd52); rst_n = 1'b1;
    cnt = 0;
    repeat (110) begin
      @(negedge clk);
      if (fire != 4'b0000) cnt++;
    end
    chk("rst_no_fire_window", 32'(cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameters: N_SLOTS, 4, number of requester slots; TW, 16, width of the time value.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cur_time  input  TW  free-running time from the timekeeper, modulo 2^TW.
REQ-005 req_valid  input  N_SLOTS  requester i asks to arm slot i.
REQ-006 req_delay  input  N_SLOTS*TW  flattened per-slot delay; slot i at bits [i*TW +: TW].
REQ-007 req_periodic  input  N_SLOTS  slot i re-arms itself after firing.
REQ-008 cancel  input  N_SLOTS  disarm slot i.
REQ-009 req_ready  output  N_SLOTS  one-hot-or-zero arm grant; combinational from req_valid and the arm pointer.
REQ-010 fire  output  N_SLOTS  registered, one-hot-or-zero alarm pulse, 1 cycle wide.
REQ-011 armed  output  N_SLOTS  slot i is in ARMED or EXPIRED.

Function
REQ-012 Each slot SHALL hold a state IDLE/ARMED/EXPIRED, a TW-bit deadline, a TW-bit period and a periodic flag.
REQ-013 At most one arm SHALL be accepted per cycle; req_ready SHALL grant the lowest index at or after the arm round-robin pointer among set req_valid bits; the pointer SHALL move to grant index+1 (mod N_SLOTS) after each acceptance.
REQ-014 On acceptance (req_valid[i] & req_ready[i]) slot i SHALL load deadline = cur_time + delay (mod 2^TW), period = delay, periodic flag = req_periodic[i], and enter ARMED; an already-ARMED/EXPIRED slot SHALL be overwritten.
REQ-015 Only delay[TW-2:0] SHALL be used (bit TW-1 ignored); delay 0 SHALL give expiry on the next edge.
REQ-016 Expiry test SHALL be the signed difference: expired when (cur_time - deadline) mod 2^TW has MSB 0; a wrapped deadline (e.g. cur_time 0xFFF0 + delay 0x20 = 0x0010) SHALL expire correctly.
REQ-017 ARMED -> EXPIRED on the edge where the expiry test is true.
REQ-018 Each cycle the fire selector SHALL pick one EXPIRED slot round-robin (fire pointer, same rule as REQ-013), register fire = one-hot of it, and advance the fire pointer.
REQ-019 Fired non-periodic slot -> IDLE; fired periodic slot -> ARMED with deadline += period (mod 2^TW); a new deadline already past SHALL expire on the following edge (no skipped pulses, no catch-up burst beyond one per expiry).
REQ-020 Unselected EXPIRED slots SHALL stay EXPIRED until fired; no expiry is ever lost.
REQ-021 Latency: cur_time equal to deadline at edge k -> EXPIRED after edge k -> fire high during cycle after edge k+1 (2 cycles), when uncontended.
REQ-022 Same-slot priority in one cycle: cancel > arm acceptance > fire selection; cancelled or newly armed slots SHALL be excluded from fire selection that cycle.
REQ-023 cancel[i] SHALL move slot i to IDLE; cancel of an IDLE slot is a no-op; req_valid with cancel on the same slot SHALL still consume the grant but leave the slot IDLE.

Reset
REQ-024 While rst_n low: all slots IDLE, deadlines/periods/flags 0, both pointers 0, fire 0, armed 0.
REQ-025 Reset asserted mid-operation SHALL discard all pending and expired alarms; no fire pulse SHALL be emitted for them after release.
REQ-026 First arm SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package alarm_pkg SHALL hold N_SLOTS, TW defaults and the slot-state enum (IDLE, ARMED, EXPIRED).
REQ-028 One sub-module rr_arbiter (request vector, pointer -> one-hot grant) SHALL be instantiated twice: arm grant and fire selection.

Verification (bench drives cur_time +1 per clk starting at 0)
REQ-029 Slot 0 arm at cur_time 10, delay 5, one-shot -> single fire=0001 pulse exactly 2 cycles after cur_time==15; armed[0] drops with it.
REQ-030 All four req_valid high in one cycle, delay 3 -> accepted over 4 consecutive cycles in order 0,1,2,3; fires in order 0,1,2,3 on consecutive cycles.
REQ-031 Slots 1 and 2 expire same edge -> fire 0010 then 0100 on consecutive cycles, neither lost.
REQ-032 Slot 3 periodic delay 4 armed at cur_time 0xFFFC -> fires at deadlines 0x0000, 0x0004, 0x0008 (+2 latency); cancel then -> no further pulses.
REQ-033 cancel[1] and req_valid[1] in the cycle slot 1 is EXPIRED -> no fire on slot 1, slot IDLE.
REQ-034 rst_n pulsed low with slots 0-2 ARMED -> armed=0000, fire stays 0 for 100 cycles after release.
